// File: rtl/zeroriscy_mmult_seq.sv
// zeroriscy_mmult_seq: steps zeroriscy_mmult through a chained int8 dot product,
// feeding each 2x16-bit result back as the next accumulate input.
module zeroriscy_mmult_seq #(
    parameter int LEN_W   = 6,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic [4:0]       cfg_param_base_i,
    input  logic [7:0]       cfg_row_i,
    input  logic [1:0]       cfg_shift_i,
    input  logic [31:0]      cfg_bias_i,
    output logic             busy_o,
    output logic             err_o,
    input  logic             act_valid_i,
    input  logic [23:0]      act_data_i,
    output logic             act_ready_o,
    output logic             res_valid_o,
    output logic [31:0]      res_data_o,
    input  logic             res_ready_i,
    output logic             mmult_en_o,
    output logic [2:0]       mmult_operator_o,
    output logic [6:0]       mmult_param_o,
    output logic [31:0]      mmult_addr_o,
    output logic [31:0]      mmult_data_o,
    input  logic [31:0]      mmult_result_i,
    input  logic             mmult_ready_i
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] len, cnt;
    logic [4:0]       idx;
    logic [7:0]       row;
    logic [1:0]       shift;
    logic [31:0]      acc;
    logic [WW-1:0]    wcnt;
    logic             err;
    logic             fire, capture, expire, last;

    assign fire    = state == ISSUE && act_valid_i && mmult_ready_i;
    // wcnt==0 guard skips a ready level left over from before the issue
    assign capture = state == WAIT && mmult_ready_i && wcnt != '0;
    assign expire  = state == WAIT && !capture && wcnt == WW'(TIMEOUT - 1);
    assign last    = (cnt + LEN_W'(1)) == len;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i) state_nx = cfg_len_i == '0 ? OUT : ISSUE;
            ISSUE:   if (fire) state_nx = WAIT;
            WAIT:    if (capture) state_nx = last ? OUT : ISSUE;
                     else if (expire) state_nx = IDLE;
            default: if (res_ready_i) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len   <= '0;
            cnt   <= '0;
            idx   <= '0;
            row   <= '0;
            shift <= '0;
            acc   <= '0;
            wcnt  <= '0;
            err   <= 1'b0;
        end else begin
            if (state == IDLE && start_i) begin
                len   <= cfg_len_i;
                idx   <= cfg_param_base_i;
                row   <= cfg_row_i;
                shift <= cfg_shift_i;
                acc   <= cfg_bias_i;
                cnt   <= '0;
                err   <= 1'b0;
            end
            if (state == WAIT) wcnt <= wcnt + WW'(1);
            if (fire) begin
                wcnt <= '0;
                idx  <= idx + 5'd1;
            end
            if (capture) begin
                acc <= mmult_result_i;
                cnt <= cnt + LEN_W'(1);
            end
            if (expire) err <= 1'b1;
        end
    end

    assign busy_o           = state != IDLE;
    assign err_o            = err;
    assign act_ready_o      = state == ISSUE && mmult_ready_i;
    assign res_valid_o      = state == OUT;
    assign res_data_o       = acc;
    assign mmult_en_o       = fire;
    assign mmult_operator_o = fire ? 3'b101 : 3'b100;
    assign mmult_param_o    = {shift, idx};
    assign mmult_addr_o     = fire ? {act_data_i, row} : 32'h0;
    assign mmult_data_o     = acc;
endmodule

// File: tb/tb_zeroriscy_mmult_seq.sv
// tb_zeroriscy_mmult_seq: directed scenarios against a 3-cycle-latency mmult stub.
module tb_zeroriscy_mmult_seq;
    logic        clk = 1'b0, rst_n = 1'b1, start_i = 1'b0;
    logic [5:0]  cfg_len_i = '0;
    logic [4:0]  cfg_param_base_i = '0;
    logic [7:0]  cfg_row_i = '0;
    logic [1:0]  cfg_shift_i = '0;
    logic [31:0] cfg_bias_i = '0;
    logic        busy_o, err_o, act_ready_o, res_valid_o;
    logic        act_valid_i = 1'b0;
    logic [23:0] act_data_i = '0;
    logic [31:0] res_data_o;
    logic        res_ready_i = 1'b1;
    logic        mmult_en_o, mmult_ready_i;
    logic [2:0]  mmult_operator_o;
    logic [6:0]  mmult_param_o;
    logic [31:0] mmult_addr_o, mmult_data_o, mmult_result_i;

    int chk = 0, fails = 0;
    int cyc = 0, en_cnt = 0, busy_cyc = 0;

    logic        stub_mode = 1'b0, stub_hang = 1'b0;
    logic [31:0] stub_val = '0, stub_res = '0;
    logic [2:0]  sc = '0;

    zeroriscy_mmult_seq dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .cfg_len_i(cfg_len_i),
        .cfg_param_base_i(cfg_param_base_i), .cfg_row_i(cfg_row_i),
        .cfg_shift_i(cfg_shift_i), .cfg_bias_i(cfg_bias_i), .busy_o(busy_o),
        .err_o(err_o), .act_valid_i(act_valid_i), .act_data_i(act_data_i),
        .act_ready_o(act_ready_o), .res_valid_o(res_valid_o), .res_data_o(res_data_o),
        .res_ready_i(res_ready_i), .mmult_en_o(mmult_en_o),
        .mmult_operator_o(mmult_operator_o), .mmult_param_o(mmult_param_o),
        .mmult_addr_o(mmult_addr_o), .mmult_data_o(mmult_data_o),
        .mmult_result_i(mmult_result_i), .mmult_ready_i(mmult_ready_i)
    );

    always #5 clk = ~clk;

    // mmult stand-in: busy for two cycles after en, ready on the third; hang mode never recovers
    assign mmult_ready_i  = sc == 3'd0;
    assign mmult_result_i = stub_res;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mmult_en_o) en_cnt <= en_cnt + 1;
        if (busy_o) busy_cyc <= busy_cyc + 1;
        if (mmult_en_o) begin
            sc       <= stub_hang ? 3'd7 : 3'd2;
            stub_res <= stub_mode ? mmult_data_o + {mmult_addr_o[31:8], 1'b0, mmult_param_o} : stub_val;
        end else if (sc != 3'd0 && !(stub_hang && sc == 3'd7)) sc <= sc - 3'd1;
    end

    task automatic start_job(input logic [5:0] len, input logic [4:0] base, input logic [7:0] row,
                             input logic [1:0] shift, input logic [31:0] bias);
        cfg_len_i = len; cfg_param_base_i = base; cfg_row_i = row;
        cfg_shift_i = shift; cfg_bias_i = bias; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = mmult_en_o;
        end
    endtask

    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = res_valid_o;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        chk++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rst_busy got=%h exp=0", busy_o); end
        chk++; if (err_o !== 1'b0) begin fails++; $display("FAIL rst_err got=%h exp=0", err_o); end
        chk++; if ({act_ready_o, res_valid_o, mmult_en_o} !== 3'b000) begin fails++; $display("FAIL rst_hs got=%b exp=000", {act_ready_o, res_valid_o, mmult_en_o}); end
        chk++; if (mmult_operator_o !== 3'b100) begin fails++; $display("FAIL rst_op got=%b exp=100", mmult_operator_o); end
        chk++; if ({mmult_param_o, mmult_addr_o, mmult_data_o, res_data_o} !== '0) begin fails++; $display("FAIL rst_data got=%h/%h/%h/%h exp=0", mmult_param_o, mmult_addr_o, mmult_data_o, res_data_o); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single;
        bit ok;
        int e0 = en_cnt, b0 = busy_cyc;
        stub_mode = 1'b0; stub_val = 32'h0A0B0C0D;
        act_valid_i = 1'b1; act_data_i = 24'h010203;
        start_job(6'd1, 5'd3, 8'h10, 2'd0, 32'h00010002);
        wait_en(ok);
        chk++; if (!ok) begin fails++; $display("FAIL single_en got=0 exp=1"); end
        chk++; if (mmult_addr_o !== 32'h01020310) begin fails++; $display("FAIL single_addr got=%h exp=01020310", mmult_addr_o); end
        chk++; if (mmult_param_o !== 7'h03) begin fails++; $display("FAIL single_param got=%h exp=03", mmult_param_o); end
        chk++; if (mmult_data_o !== 32'h00010002) begin fails++; $display("FAIL single_data got=%h exp=00010002", mmult_data_o); end
        chk++; if (mmult_operator_o !== 3'b101) begin fails++; $display("FAIL single_op got=%b exp=101", mmult_operator_o); end
        @(posedge clk); #1 act_valid_i = 1'b0;
        wait_res(ok);
        chk++; if (!ok || res_data_o !== 32'h0A0B0C0D) begin fails++; $display("FAIL single_res got=%h valid=%0d exp=0a0b0c0d", res_data_o, ok); end
        @(posedge clk); #1;
        chk++; if (en_cnt - e0 != 1) begin fails++; $display("FAIL single_en_count got=%0d exp=1", en_cnt - e0); end
        chk++; if (busy_cyc - b0 != 5) begin fails++; $display("FAIL single_busy got=%0d exp=5", busy_cyc - b0); end
    endtask

    task automatic test_chain;
        bit ok;
        int prev = 0;
        logic [23:0] acts [3];
        logic [6:0]  eparam [3];
        logic [31:0] edata [3];
        acts = '{24'h000001, 24'h000002, 24'h000003};
        eparam = '{7'h3F, 7'h20, 7'h21};
        edata = '{32'h00000100, 32'h0000023F, 32'h0000045F};
        stub_mode = 1'b1;
        act_valid_i = 1'b1; act_data_i = acts[0];
        start_job(6'd3, 5'd31, 8'h20, 2'd1, 32'h00000100);
        for (int k = 0; k < 3; k++) begin
            wait_en(ok);
            chk++; if (!ok) begin fails++; $display("FAIL chain_en%0d got=0 exp=1", k); end
            chk++; if (mmult_param_o !== eparam[k]) begin fails++; $display("FAIL chain_param%0d got=%h exp=%h", k, mmult_param_o, eparam[k]); end
            chk++; if (mmult_data_o !== edata[k]) begin fails++; $display("FAIL chain_data%0d got=%h exp=%h", k, mmult_data_o, edata[k]); end
            chk++; if (mmult_addr_o !== {acts[k], 8'h20}) begin fails++; $display("FAIL chain_addr%0d got=%h exp=%h", k, mmult_addr_o, {acts[k], 8'h20}); end
            if (k > 0) begin
                chk++; if (cyc - prev != 4) begin fails++; $display("FAIL chain_gap%0d got=%0d exp=4", k, cyc - prev); end
            end
            prev = cyc;
            @(posedge clk); #1;
            if (k < 2) act_data_i = acts[k + 1];
            else act_valid_i = 1'b0;
        end
        wait_res(ok);
        chk++; if (!ok || res_data_o !== 32'h00000780) begin fails++; $display("FAIL chain_res got=%h valid=%0d exp=00000780", res_data_o, ok); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall;
        bit ok;
        int e0 = en_cnt;
        stub_mode = 1'b1;
        act_valid_i = 1'b1; act_data_i = 24'h000005;
        start_job(6'd2, 5'd0, 8'h00, 2'd0, 32'h0);
        wait_en(ok);
        chk++; if (!ok || mmult_addr_o !== 32'h00000500) begin fails++; $display("FAIL stall_first got=%h exp=00000500", mmult_addr_o); end
        @(posedge clk); #1 act_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk++; if ({mmult_en_o, busy_o, act_ready_o} !== 3'b011) begin fails++; $display("FAIL stall_hold%0d got=%b exp=011", i, {mmult_en_o, busy_o, act_ready_o}); end
        end
        @(posedge clk); #1;
        act_valid_i = 1'b1; act_data_i = 24'h000007;
        wait_en(ok);
        chk++; if (!ok || mmult_data_o !== 32'h00000500 || mmult_param_o !== 7'h01) begin fails++; $display("FAIL stall_second got=%h/%h exp=00000500/01", mmult_data_o, mmult_param_o); end
        @(posedge clk); #1 act_valid_i = 1'b0;
        wait_res(ok);
        chk++; if (!ok || res_data_o !== 32'h00000C01) begin fails++; $display("FAIL stall_res got=%h exp=00000c01", res_data_o); end
        chk++; if (en_cnt - e0 != 2) begin fails++; $display("FAIL stall_en_count got=%0d exp=2", en_cnt - e0); end
        @(posedge clk); #1;
    endtask

    task automatic test_out_hold;
        bit ok;
        int e0 = en_cnt;
        stub_mode = 1'b0; stub_val = 32'h12345678; res_ready_i = 1'b0;
        act_valid_i = 1'b1; act_data_i = 24'h0000AA;
        start_job(6'd1, 5'd7, 8'h01, 2'd3, 32'h0);
        wait_en(ok);
        @(posedge clk); #1 act_valid_i = 1'b0;
        wait_res(ok);
        chk++; if (!ok) begin fails++; $display("FAIL hold_valid got=0 exp=1"); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start_i = 1'b1; cfg_len_i = 6'd0; cfg_bias_i = 32'hFFFFFFFF;
            @(negedge clk);
            chk++; if (res_valid_o !== 1'b1 || res_data_o !== 32'h12345678) begin fails++; $display("FAIL hold_stable%0d got=%b/%h exp=1/12345678", i, res_valid_o, res_data_o); end
        end
        start_i = 1'b0; res_ready_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk++; if (busy_o !== 1'b0 || res_valid_o !== 1'b0) begin fails++; $display("FAIL hold_release got=%b%b exp=00", busy_o, res_valid_o); end
        chk++; if (en_cnt - e0 != 1) begin fails++; $display("FAIL hold_en_count got=%0d exp=1", en_cnt - e0); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int e0 = en_cnt;
        start_job(6'd0, 5'd9, 8'h00, 2'd0, 32'hDEADBEEF);
        @(negedge clk);
        chk++; if (res_valid_o !== 1'b1 || res_data_o !== 32'hDEADBEEF) begin fails++; $display("FAIL len0_res got=%b/%h exp=1/deadbeef", res_valid_o, res_data_o); end
        @(posedge clk); #1;
        start_job(6'd0, 5'd0, 8'h00, 2'd0, 32'h01234567);
        @(negedge clk);
        chk++; if (res_valid_o !== 1'b1 || res_data_o !== 32'h01234567) begin fails++; $display("FAIL b2b_res got=%b/%h exp=1/01234567", res_valid_o, res_data_o); end
        @(posedge clk); #1;
        chk++; if (en_cnt - e0 != 0) begin fails++; $display("FAIL len0_en_count got=%0d exp=0", en_cnt - e0); end
    endtask

    task automatic test_timeout;
        bit ok, rv = 1'b0, done = 1'b0;
        int n = 0;
        stub_hang = 1'b1;
        act_valid_i = 1'b1; act_data_i = 24'h000011;
        start_job(6'd1, 5'd2, 8'h00, 2'd0, 32'h0);
        wait_en(ok);
        chk++; if (!ok) begin fails++; $display("FAIL to_en got=0 exp=1"); end
        @(posedge clk); #1 act_valid_i = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (res_valid_o) rv = 1'b1;
            if (busy_o) n++;
            else done = 1'b1;
        end
        chk++; if (!done || n != 15) begin fails++; $display("FAIL to_wait got=%0d exp=15", n); end
        chk++; if (rv !== 1'b0) begin fails++; $display("FAIL to_nores got=1 exp=0"); end
        chk++; if (err_o !== 1'b1) begin fails++; $display("FAIL to_err got=%b exp=1", err_o); end
        stub_hang = 1'b0;
        @(posedge clk); #1;
        start_job(6'd0, 5'd0, 8'h00, 2'd0, 32'h55);
        @(negedge clk);
        chk++; if (err_o !== 1'b0) begin fails++; $display("FAIL to_clear got=%b exp=0", err_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait;
        bit ok, rv = 1'b0, bz = 1'b0;
        stub_hang = 1'b1;
        act_valid_i = 1'b1; act_data_i = 24'h000022;
        start_job(6'd1, 5'd5, 8'h33, 2'd2, 32'hCAFE0001);
        wait_en(ok);
        chk++; if (!ok) begin fails++; $display("FAIL rmw_en got=0 exp=1"); end
        @(posedge clk); #1 act_valid_i = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk++; if ({busy_o, err_o, act_ready_o, res_valid_o, mmult_en_o} !== 5'b0) begin fails++; $display("FAIL rmw_ctl got=%b exp=00000", {busy_o, err_o, act_ready_o, res_valid_o, mmult_en_o}); end
        chk++; if ({mmult_param_o, mmult_addr_o, mmult_data_o, res_data_o} !== '0 || mmult_operator_o !== 3'b100) begin fails++; $display("FAIL rmw_data got=%h/%h/%h/%h op=%b exp=0 op=100", mmult_param_o, mmult_addr_o, mmult_data_o, res_data_o, mmult_operator_o); end
        @(posedge clk); #1;
        rst_n = 1'b1; stub_hang = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid_o) rv = 1'b1;
            if (busy_o) bz = 1'b1;
        end
        chk++; if (rv !== 1'b0 || bz !== 1'b0) begin fails++; $display("FAIL rmw_idle got=%b%b exp=00", rv, bz); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_chain;
        test_stall;
        test_out_hold;
        test_back_to_back;
        test_timeout;
        test_reset_mid_wait;
        $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
        $finish;
    end
endmodule

// File: doc/zeroriscy_mmult_seq.md
Name: zeroriscy_mmult_seq

Overview:
Micro-sequencer that drives the zeroriscy_mmult int8 inner-product unit through a multi-step dot product without core involvement. The core programs a job: length, parameter base index, row offset, shift and bias. The sequencer then pulls one packed activation word per step from a stream, issues one mmult32 operation per step, and chains each 2x16-bit result into the next step's accumulate input. The final accumulator is returned on a result stream. It sits between the EX stage / CSR interface and zeroriscy_mmult, and drives that unit's enable, operator, param, addr and data inputs.

Parameters:
LEN_W, 6, width of cfg_len_i; a job is 0..2^LEN_W-1 steps.
TIMEOUT, 15, maximum cycles in WAIT before the job aborts with an error.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start_i  in  1  start job; sampled only in IDLE
cfg_len_i  in  LEN_W  number of steps
cfg_param_base_i  in  5  param index of step 0
cfg_row_i  in  8  row offset, driven on mmult_addr_o[7:0]
cfg_shift_i  in  2  result shift select, driven on mmult_param_o[6:5]
cfg_bias_i  in  32  initial accumulator {hi16,lo16}
busy_o  out  1  high whenever state != IDLE
err_o  out  1  sticky timeout flag; cleared by the next accepted start_i
act_valid_i  in  1  activation word valid
act_data_i  in  24  three signed int8 activations
act_ready_o  out  1  activation accepted when valid&ready
res_valid_o  out  1  final result valid
res_data_o  out  32  final accumulator
res_ready_i  in  1  result consumer ready
mmult_en_o  out  1  to mmult_en_i
mmult_operator_o  out  3  101 when mmult_en_o, else 100
mmult_param_o  out  7  {shift, param index}
mmult_addr_o  out  32  {act_data_i, cfg_row}
mmult_data_o  out  32  current accumulator
mmult_result_i  in  32  from mmult_result_o
mmult_ready_i  in  1  from mmult_ready_o

Behaviour:
- States: IDLE, ISSUE, WAIT, OUT. Reset (asynchronous) forces IDLE. All outputs reset to 0 except mmult_operator_o=100. acc, step count, param index, err and wait counter reset to 0.
- IDLE: start_i=1 latches len, base, row, shift; sets acc<=cfg_bias_i, idx<=base, cnt<=0, err<=0.
  - Next state is OUT if len==0, else ISSUE.
  - start_i is ignored outside IDLE.
- ISSUE: act_ready_o = mmult_ready_i. mmult_en_o = act_valid_i & mmult_ready_i, so activation consumption and issue are the same event.
  - addr_o, param_o and data_o are combinational from act_data_i and registers; they are valid whenever en_o=1.
  - On fire: go to WAIT, clear wait counter, idx<=idx+1 (mod 32 wrap).
  - No fire: hold state, no side effects.
- WAIT: en_o=0, act_ready_o=0, wait counter increments each cycle.
  - The result is captured on the first WAIT cycle with mmult_ready_i=1 and wait counter>=1. Nominally this is the 3rd cycle after the issue edge, giving 4 cycles per step.
  - Capture: acc<=mmult_result_i, cnt<=cnt+1. Next state is OUT if cnt+1==len, else ISSUE.
  - If the wait counter reaches TIMEOUT without capture: err<=1, go to IDLE, drop the job (no result emitted).
- OUT: res_valid_o=1, res_data_o=acc, held stable until res_ready_i=1, then go to IDLE. A consumer already asserting ready completes in 1 cycle.
- Back-to-back: a job started in the cycle after OUT completes is legal.
- No arithmetic is done in the sequencer. Saturation, wrap and shift all happen in the mmult unit; acc is a plain 32-bit register.
- Reset mid-job: no result is emitted. The mmult pipeline is not reset, so the first issue after reset is gated by mmult_ready_i, which naturally drains any in-flight op.

Test Plan:
- len=1, base=3, row=0x10, shift=0, bias=0x00010002, act=0x010203; mmult stub returns 0x0A0B0C0D 3 cycles after en -> one en pulse with addr=0x01020310, param=0x03, data=0x00010002; res_data_o=0x0A0B0C0D; busy 5 cycles.
- len=3, base=31 -> param idx 31,0,1 (wrap); each step's mmult_data_o equals the previous result; en pulses exactly 4 cycles apart.
- act_valid_i low 5 cycles in step 2 -> no en, state holds ISSUE, no act accepted; completes correctly afterwards.
- res_ready_i low 10 cycles -> res_valid_o and data stable; start_i pulses during OUT are ignored.
- len=0, bias=0xDEADBEEF -> OUT the cycle after start, res_data_o=0xDEADBEEF, zero en pulses.
- Stub never raises ready after issue -> IDLE after 15 WAIT cycles, err_o=1, no res_valid_o; next start clears err_o. Repeat with rst_n low mid-WAIT -> all outputs 0 immediately.
